// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, register map and status bit layout.
// Optional even-parity reception is built when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int DEFAULT_CLOCKS_PER_BIT = 434;
  localparam int DEFAULT_FIFO_DEPTH     = 8;

  localparam logic UART_RX_STATUS_ADDR = 1'b0;
  localparam logic UART_RX_DATA_ADDR   = 1'b1;

  localparam int STAT_NOT_EMPTY_BIT = 0;
  localparam int STAT_OVERRUN_BIT   = 1;
  localparam int STAT_FRAMING_BIT   = 2;
  localparam int STAT_PARITY_BIT    = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_t;

  // Even parity: data bits plus the parity bit must XOR to zero.
  function automatic logic even_parity_bad(input logic [7:0] data, input logic parity_bit);
    return ^{data, parity_bit};
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received bytes; head is presented combinationally on dout.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (count == '0);
    full    = (count == DEPTH_C);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_receiver_interface.sv
// UART 8N1 receiver with a 2-word bus register map (status at 0, data/pop at 1).
// Defining UART_RX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module uart_receiver_interface
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT,
  parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        addr,
  input  logic [31:0] write_data,
  input  logic [3:0]  byte_enable,
  input  logic        write_req,
  input  logic        read_req,
  output logic [31:0] read_data,
  output logic        read_data_valid
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLOCKS_PER_BIT / 2 - 1);

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_sync_d;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;

  logic             overrun;
  logic             framing_err;
  logic             parity_err;

  logic             sample_tick;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [7:0]       fifo_dout;
  logic             framing_set;
  logic             overrun_set;
  logic             parity_set;
  logic             status_wr;
  logic [31:0]      status_word;
  logic             unused_bus_bits;

  assign unused_bus_bits = ^{write_data, byte_enable};

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_sync_d <= 1'b1;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_sync_d <= rx_sync;
    end
  end

  always_comb begin
    sample_tick = (baud_cnt == '0);
    fifo_push   = (rx_state == STOP) && sample_tick && rx_sync;
    framing_set = (rx_state == STOP) && sample_tick && !rx_sync;
`ifdef UART_RX_PARITY_EN
    parity_set  = (rx_state == PARITY) && sample_tick && even_parity_bad(shift_reg, rx_sync);
`else
    parity_set  = 1'b0;
`endif
    fifo_pop    = read_req && (addr == UART_RX_DATA_ADDR) && !fifo_empty;
    overrun_set = fifo_push && fifo_full && !fifo_pop;
    status_wr   = write_req && (addr == UART_RX_STATUS_ADDR) && byte_enable[0];
    status_word = {28'b0, parity_err, framing_err, overrun, !fifo_empty};
  end

  // Receive FSM; rx_state is the observable state for bound checkers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state  <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      case (rx_state)
        IDLE: begin
          if (rx_sync_d && !rx_sync) begin
            baud_cnt <= CNT_HALF;
            rx_state <= START;
          end
        end
        START: begin
          if (sample_tick) begin
            if (!rx_sync) begin
              baud_cnt <= CNT_BIT;
              bit_idx  <= '0;
              rx_state <= DATA;
            end else begin
              rx_state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - CNT_W'(1);
          end
        end
        DATA: begin
          if (sample_tick) begin
            shift_reg <= {rx_sync, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            baud_cnt  <= CNT_BIT;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              rx_state <= PARITY;
`else
              rx_state <= STOP;
`endif
            end
          end else begin
            baud_cnt <= baud_cnt - CNT_W'(1);
          end
        end
        PARITY: begin
          if (sample_tick) begin
            baud_cnt <= CNT_BIT;
            rx_state <= STOP;
          end else begin
            baud_cnt <= baud_cnt - CNT_W'(1);
          end
        end
        STOP: begin
          if (sample_tick) begin
            rx_state <= rx_sync ? IDLE : BREAK_WAIT;
          end else begin
            baud_cnt <= baud_cnt - CNT_W'(1);
          end
        end
        BREAK_WAIT: begin
          if (rx_sync) rx_state <= IDLE;
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      overrun     <= overrun_set |
                     (overrun & ~(status_wr & write_data[STAT_OVERRUN_BIT]));
      framing_err <= framing_set |
                     (framing_err & ~(status_wr & write_data[STAT_FRAMING_BIT]));
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= parity_set |
                    (parity_err & ~(status_wr & write_data[STAT_PARITY_BIT]));
    end
  end
`else
  assign parity_err = parity_set;
`endif

  // Bus handshake: read_req is a one-cycle strobe with no back-pressure; read_data_valid
  // pulses exactly one cycle later with read_data, and read_data holds until the next read.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data       <= '0;
      read_data_valid <= 1'b0;
    end else begin
      read_data_valid <= read_req;
      if (read_req) begin
        if (addr == UART_RX_STATUS_ADDR) begin
          read_data <= status_word;
        end else if (fifo_empty) begin
          read_data <= '0;
        end else begin
          read_data <= {24'b0, fifo_dout};
        end
      end
    end
  end

  uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (shift_reg),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

endmodule

// File: tb/tb_uart_receiver_interface.sv
// Bench for uart_receiver_interface (CLOCKS_PER_BIT=16, FIFO_DEPTH=4): table-driven bus
// sequences plus hand-written frame corner cases; read results are scored from an expected queue.
module tb_uart_receiver_interface;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  // Start edge driven at cycle 0: 2 sync flops + edge detect + half bit + 9 full bits.
`ifdef UART_RX_PARITY_EN
  localparam int STOP_CYC = 171;
`else
  localparam int STOP_CYC = 155;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        addr;
  logic [31:0] write_data;
  logic [3:0]  byte_enable;
  logic        write_req;
  logic        read_req;
  logic [31:0] read_data;
  logic        read_data_valid;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        req_q = 1'b0;

  typedef enum {OP_SEND, OP_READ, OP_WRITE} op_t;
  typedef struct {
    op_t         op;
    logic        a;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  uart_receiver_interface #(
    .CLOCKS_PER_BIT (CPB),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rx              (rx),
    .addr            (addr),
    .write_data      (write_data),
    .byte_enable     (byte_enable),
    .write_req       (write_req),
    .read_req        (read_req),
    .read_data       (read_data),
    .read_data_valid (read_data_valid)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input op_t op, input logic a, input logic [31:0] d,
                              input logic [3:0] be, input logic [31:0] e);
    vec_t v;
    v.op = op; v.a = a; v.data = d; v.be = be; v.exp = e;
    return v;
  endfunction

  // Scoreboard: every accepted read must be answered one cycle later, in order.
  always @(posedge clk) req_q <= read_req && !reset;

  always @(negedge clk) begin
    if (!reset) begin
      if (read_data_valid || req_q) check("valid_timing", {31'b0, read_data_valid}, {31'b0, req_q});
      if (read_data_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_read_data", 32'h1, 32'h0);
        end else begin
          check(name_q.pop_front(), read_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic bad_par,
                            input int extra_low);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ bad_par;
    repeat (CPB) @(negedge clk);
`endif
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    repeat (extra_low) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic bus_read(input logic a, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    addr     = a;
    read_req = 1'b1;
    @(negedge clk);
    read_req = 1'b0;
  endtask

  task automatic bus_write(input logic a, input logic [31:0] d, input logic [3:0] be);
    addr        = a;
    write_data  = d;
    byte_enable = be;
    write_req   = 1'b1;
    @(negedge clk);
    write_req   = 1'b0;
    byte_enable = 4'h0;
  endtask

  initial begin
    rx = 1'b1; reset = 1'b1; addr = 1'b0; write_data = '0;
    byte_enable = 4'h0; write_req = 1'b0; read_req = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_read_data", read_data, 32'h0);
    check("reset_valid", {31'b0, read_data_valid}, 32'h0);
    reset = 1'b0;
    idle(4);
    bus_read(1'b0, 32'h0, "status_after_reset");
    idle(2);

    // Single byte, then overrun of a 4-deep FIFO and flag clearing.
    vecs.push_back(mk(OP_SEND,  1'b0, 32'hA5, 4'h0, 32'h0));
    vecs.push_back(mk(OP_READ,  1'b0, 32'h0,  4'h0, 32'h1));
    vecs.push_back(mk(OP_READ,  1'b1, 32'h0,  4'h0, 32'hA5));
    vecs.push_back(mk(OP_READ,  1'b0, 32'h0,  4'h0, 32'h0));
    for (int i = 1; i <= 5; i++) vecs.push_back(mk(OP_SEND, 1'b0, 32'(i), 4'h0, 32'h0));
    vecs.push_back(mk(OP_READ,  1'b0, 32'h0,  4'h0, 32'h3));
    for (int i = 1; i <= 4; i++) vecs.push_back(mk(OP_READ, 1'b1, 32'h0, 4'h0, 32'(i)));
    vecs.push_back(mk(OP_READ,  1'b1, 32'h0,  4'h0, 32'h0));
    vecs.push_back(mk(OP_READ,  1'b0, 32'h0,  4'h0, 32'h2));
    vecs.push_back(mk(OP_WRITE, 1'b0, 32'h2,  4'h0, 32'h0));
    vecs.push_back(mk(OP_WRITE, 1'b1, 32'h2,  4'h1, 32'h0));
    vecs.push_back(mk(OP_READ,  1'b0, 32'h0,  4'h0, 32'h2));
    vecs.push_back(mk(OP_WRITE, 1'b0, 32'h2,  4'h1, 32'h0));
    vecs.push_back(mk(OP_READ,  1'b0, 32'h0,  4'h0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_SEND:  begin send_frame(vecs[i].data[7:0], 1'b1, 1'b0, 0); idle(4); end
        OP_READ:  bus_read(vecs[i].a, vecs[i].exp, $sformatf("vec%0d", i));
        OP_WRITE: bus_write(vecs[i].a, vecs[i].data, vecs[i].be);
        default:  ;
      endcase
    end
    idle(3);

    // Framing error followed by a held break, then normal reception resumes.
    send_frame(8'h3C, 1'b0, 1'b0, 40);
    idle(4);
    bus_read(1'b0, 32'h4, "framing_status");
    send_frame(8'h7E, 1'b1, 1'b0, 0);
    idle(4);
    bus_read(1'b0, 32'h5, "after_break_status");
    bus_read(1'b1, 32'h7E, "after_break_data");
    bus_write(1'b0, 32'h4, 4'h1);
    bus_read(1'b0, 32'h0, "framing_cleared");
    idle(3);

    // Short glitch on the idle line.
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(30);
    bus_read(1'b0, 32'h0, "glitch_status");
    bus_read(1'b1, 32'h0, "glitch_data");
    idle(3);

    // Reset during data bit 4 of 0x55, with a read strobe held during reset.
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = (i % 2 == 0) ? 1'b1 : 1'b0;
      idle(CPB);
    end
    rx = 1'b1;
    idle(CPB / 2);
    reset    = 1'b1;
    addr     = 1'b0;
    read_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("valid_in_reset%0d", i), {31'b0, read_data_valid}, 32'h0);
    end
    read_req = 1'b0;
    reset    = 1'b0;
    idle(20);
    send_frame(8'h99, 1'b1, 1'b0, 0);
    idle(4);
    bus_read(1'b0, 32'h1, "post_reset_status");
    bus_read(1'b1, 32'h99, "post_reset_data");
    bus_read(1'b0, 32'h0, "post_reset_empty");
    idle(3);

    // Full FIFO with a pop landing on the stop-bit sample of the next byte.
    send_frame(8'h11, 1'b1, 1'b0, 0); idle(4);
    send_frame(8'h22, 1'b1, 1'b0, 0); idle(4);
    send_frame(8'h33, 1'b1, 1'b0, 0); idle(4);
    send_frame(8'h44, 1'b1, 1'b0, 0); idle(4);
    fork
      send_frame(8'h66, 1'b1, 1'b0, 0);
      begin
        idle(STOP_CYC - 1);
        bus_read(1'b1, 32'h11, "pop_at_push");
      end
    join
    idle(4);
    bus_read(1'b0, 32'h1, "no_overrun_status");
    bus_read(1'b1, 32'h22, "full_data1");
    bus_read(1'b1, 32'h33, "full_data2");
    bus_read(1'b1, 32'h44, "full_data3");
    bus_read(1'b1, 32'h66, "full_data4");
    bus_read(1'b0, 32'h0, "full_drained");
    idle(3);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h5A, 1'b1, 1'b1, 0);
    idle(4);
    bus_read(1'b0, 32'h9, "parity_status");
    bus_read(1'b1, 32'h5A, "parity_data");
    bus_write(1'b0, 32'h8, 4'h1);
    bus_read(1'b0, 32'h0, "parity_cleared");
    idle(3);
`endif

    idle(5);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
